// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, holds the word until the core accepts it.
// Fetch to valid in 1 cycle plus memory wait states; a stall freezes the held word and defers the next request.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_off,
  input  logic        jump,
  input  logic [25:0] jump_idx,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic [15:0] inst_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] inst_q;
  logic [31:0] inst_addr_q;
  logic [15:0] count_q;
  logic [15:0] count_d;
  logic [31:0] link_addr;
  logic [31:0] branch_disp;

  assign link_addr   = inst_addr_q + 32'd4;
  assign branch_disp = {{14{branch_off[15]}}, branch_off, 2'b00};
  assign count_d     = count_q + 16'd1;

  // Redirect target relative to the held instruction; jump has priority over branch.
  always_comb begin
    pc_d = link_addr;
    if (jump) begin
      pc_d = {link_addr[31:28], jump_idx, 2'b00};
    end else if (branch_taken) begin
      pc_d = link_addr + branch_disp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= 32'd0;
      inst_addr_q <= 32'd0;
      count_q     <= 16'd0;
    end else begin
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            inst_q      <= imem_rdata;
            inst_addr_q <= pc_q;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_q    <= pc_d;
            count_q <= count_d;
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req   = (state_q == FETCH);
  assign inst_valid = (state_q == HOLD);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_addr  = inst_addr_q;
  assign pc_plus4   = link_addr;
  assign inst_count = count_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed fetch/redirect/reset scenarios then randomized
// transactions (wait states, stalls, redirects) checked against a transaction-level PC model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_off;
  logic        jump;
  logic [25:0] jump_idx;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic [15:0] inst_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc;
  logic [15:0] exp_cnt;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump         (jump),
    .jump_idx     (jump_idx),
    .inst         (inst),
    .inst_addr    (inst_addr),
    .pc_plus4     (pc_plus4),
    .inst_valid   (inst_valid),
    .inst_count   (inst_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule, written as plain address arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] addr, input bit br,
                                             input logic [15:0] off, input bit jp,
                                             input logic [25:0] idx);
    logic [31:0] seq;
    int signed   soff;
    seq = addr + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | (32'(idx) * 32'd4);
    if (br) begin
      soff = int'($signed(off));
      return seq + 32'(soff * 4);
    end
    return seq;
  endfunction

  task automatic scramble_ctrl();
    branch_taken = 1'($urandom);
    jump         = 1'($urandom);
    branch_off   = 16'($urandom);
    jump_idx     = 26'($urandom);
  endtask

  // One full instruction: wait states, ack, stall cycles, accept with a redirect decision.
  task automatic do_fetch(input int waits, input int stalls, input bit br, input logic [15:0] off,
                          input bit jp, input logic [25:0] idx, input logic [31:0] data);
    logic [31:0] held_addr;
    chk("req_in_fetch", 32'(imem_req), 32'd1);
    chk("addr_in_fetch", imem_addr, exp_pc);
    chk("novalid_in_fetch", 32'(inst_valid), 32'd0);
    for (int w = 0; w < waits; w++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      scramble_ctrl();
      step();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_novalid", 32'(inst_valid), 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    scramble_ctrl();
    step();
    held_addr = exp_pc;
    chk("hold_valid", 32'(inst_valid), 32'd1);
    chk("hold_noreq", 32'(imem_req), 32'd0);
    chk("hold_inst", inst, data);
    chk("hold_addr", inst_addr, held_addr);
    chk("hold_pc4", pc_plus4, held_addr + 32'd4);
    chk("hold_count", 32'(inst_count), 32'(exp_cnt));
    for (int s = 0; s < stalls; s++) begin
      stall = 1'b1;
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      scramble_ctrl();
      step();
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_noreq", 32'(imem_req), 32'd0);
      chk("stall_inst", inst, data);
      chk("stall_addr", inst_addr, held_addr);
      chk("stall_count", 32'(inst_count), 32'(exp_cnt));
    end
    stall = 1'b0;
    imem_ack = 1'($urandom);
    imem_rdata = $urandom;
    branch_taken = br;
    branch_off = off;
    jump = jp;
    jump_idx = idx;
    step();
    exp_pc = model_next(held_addr, br, off, jp, idx);
    exp_cnt = exp_cnt + 16'd1;
    imem_ack = 1'b0;
    branch_taken = 1'b0;
    jump = 1'b0;
    chk("accept_req", 32'(imem_req), 32'd1);
    chk("accept_next_addr", imem_addr, exp_pc);
    chk("accept_novalid", 32'(inst_valid), 32'd0);
    chk("accept_count", 32'(inst_count), 32'(exp_cnt));
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_off = 16'd0;
    jump = 1'b0;
    jump_idx = 26'd0;
    exp_pc = 32'd0;
    exp_cnt = 16'd0;
    step();
    step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_addr", inst_addr, 32'd0);
    chk("rst_pc4", pc_plus4, 32'd4);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_count", 32'(inst_count), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_noreq", 32'(imem_req), 32'd0);
    step();

    // Sequential fetches, then wait states at 0x4 and a stall at 0x8.
    do_fetch(0, 0, 0, 16'h0, 0, 26'h0, 32'h0000_0000);
    do_fetch(3, 0, 0, 16'h0, 0, 26'h0, 32'h0000_0004);
    do_fetch(0, 3, 0, 16'h0, 0, 26'h0, 32'h0000_0008);
    do_fetch(0, 0, 0, 16'h0, 0, 26'h0, 32'h0000_000C);
    chk("count_after4", 32'(inst_count), 32'd4);
    // Redirects: branch back, jump, jump+branch together, branch wrapping below zero.
    do_fetch(0, 0, 1, 16'hFFFC, 0, 26'h0, 32'h0000_0010);
    chk("branch_back_addr", imem_addr, 32'h0000_0004);
    do_fetch(0, 0, 0, 16'h0, 1, 26'h4, 32'h0000_0004);
    do_fetch(1, 0, 0, 16'h0, 1, 26'h40, 32'h0000_0010);
    chk("jump_addr", imem_addr, 32'h0000_0100);
    do_fetch(0, 1, 0, 16'h0, 1, 26'h4, 32'h0000_0100);
    do_fetch(0, 0, 1, 16'hFFFC, 1, 26'h40, 32'h0000_0010);
    chk("jump_wins_addr", imem_addr, 32'h0000_0100);
    do_fetch(0, 0, 1, 16'hFFC3, 0, 26'h0, 32'h0000_0100);
    do_fetch(0, 0, 1, 16'hFFFA, 0, 26'h0, 32'h0000_0010);
    chk("wrap_below_zero", imem_addr, 32'hFFFF_FFFC);
    do_fetch(2, 0, 0, 16'h0, 0, 26'h0, 32'hFFFF_FFFC);
    chk("pc_wrap_next", imem_addr, 32'h0000_0000);
    do_fetch(0, 0, 0, 16'h0, 1, 26'h8, 32'h1234_5678);

    // Reset while a fetch at 0x20 is outstanding; acks around reset must be ignored.
    chk("pre_reset_addr", imem_addr, 32'h0000_0020);
    step();
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_noreq", 32'(imem_req), 32'd0);
    chk("midrst_novalid", 32'(inst_valid), 32'd0);
    chk("midrst_addr", imem_addr, 32'h0000_0000);
    chk("midrst_count", 32'(inst_count), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    step();
    imem_ack = 1'b0;
    chk("post_rst_novalid", 32'(inst_valid), 32'd0);
    chk("post_rst_inst", inst, 32'd0);
    exp_pc = 32'd0;
    exp_cnt = 16'd0;
    do_fetch(0, 0, 0, 16'h0, 0, 26'h0, 32'hCAFE_0000);

    // Randomized transactions.
    for (int n = 0; n < 300; n++) begin
      do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               1'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0),
               26'($urandom), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage that sits directly upstream of the single-cycle MIPS datapath. It owns the program counter and issues request/acknowledge fetches to instruction memory. It presents each fetched word with its address and a valid flag, and computes the next PC from the branch and jump decisions returned by the core. The memory interface tolerates any number of wait states, and the consumer side supports stalls.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals current PC.
- imem_ack  input  1  memory has placed valid data on imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- stall  input  1  core cannot accept the presented instruction this cycle.
- branch_taken  input  1  held instruction is a taken branch.
- branch_off  input  16  branch immediate (inst[15:0]).
- jump  input  1  held instruction is a J/JAL.
- jump_idx  input  26  jump index (inst[25:0]).
- inst  output  32  instruction word presented to the core.
- inst_addr  output  32  PC of inst.
- pc_plus4  output  32  inst_addr + 4, for JAL link and branch base.
- inst_valid  output  1  inst/inst_addr are valid.
- inst_count  output  16  count of accepted instructions.

## Operation
- FSM states: IDLE, FETCH, HOLD.
  - IDLE: entered on reset. Goes to FETCH on the first rising edge after rst_n deasserts.
  - FETCH: imem_req=1 and imem_addr=pc. On a clk edge with imem_ack=1: inst<=imem_rdata, inst_addr<=pc, go to HOLD.
  - HOLD: inst_valid=1 and imem_req=0.
    - Accept = edge with stall=0: pc<=next_pc, inst_count<=inst_count+1, go to FETCH.
    - stall=1: remain in HOLD; all outputs frozen.
- next_pc is evaluated only on accept, relative to inst_addr:
  - jump=1: {pc_plus4[31:28], jump_idx, 2'b00}.
  - else branch_taken=1: pc_plus4 + ({{14{branch_off[15]}}, branch_off, 2'b00}), modulo 2^32.
  - else: pc_plus4.
  - jump and branch_taken both 1: jump wins.
- branch_taken, jump, and their operands are ignored outside HOLD and on stalled cycles.
- imem_ack outside FETCH is ignored; no data is latched.
- Arithmetic rules:
  - pc_plus4 wraps 0xFFFF_FFFC -> 0x0000_0000.
  - inst_count wraps 0xFFFF -> 0x0000.
- Reset mid-operation: all state returns to its reset values immediately, regardless of FSM state. Any ack for an aborted fetch is ignored, and fetching restarts at RESET_PC.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - inst=0, inst_addr=0, pc_plus4=4, inst_valid=0, inst_count=0.
- imem_req and inst_valid are decoded from registered state only, with no combinational path from inputs. imem_addr is driven from the pc register.
- imem_addr is stable for the entire time imem_req=1.
- Zero-wait memory (ack in the first FETCH cycle): inst_valid asserts 1 cycle after the request cycle.
- With zero wait states and no stalls, the unit fetches one instruction every 2 cycles: FETCH, HOLD, FETCH, HOLD, ...
- Each memory wait cycle adds 1 cycle; each stall cycle adds 1 cycle.
- After accept, imem_req for next_pc is asserted on the next cycle.
- First request is made in the 2nd cycle after reset release (IDLE occupies 1 cycle).

## Test plan
- Reset, then zero-wait memory returning word = address, stall=0:
  - imem_addr sequence 0x0, 0x4, 0x8, 0xC.
  - inst_valid high on alternate cycles; inst matches inst_addr.
  - inst_count reaches 4.
- Memory acks 3 cycles after the request:
  - imem_addr held at 0x4 and imem_req held high for 3 cycles; inst_valid=0 throughout.
  - inst=0x4 is presented on the cycle after the ack.
- stall=1 for 3 cycles while inst_addr=0x8:
  - inst, inst_addr, and inst_valid stay unchanged; imem_req=0; inst_count unchanged.
  - When stall drops, the next request is for 0xC.
- Redirects:
  - Branch at inst_addr 0x10 with branch_off=0xFFFC: next imem_addr=0x04.
  - Jump at 0x10 with jump_idx=0x0000040: next imem_addr=0x100.
  - Both asserted together: 0x100.
- rst_n pulsed low while in FETCH at 0x20 (ack pending):
  - imem_req drops immediately and inst_valid=0.
  - An ack arriving during or after reset is ignored.
  - The next request is for RESET_PC.
- inst_count wrap: 65536 accepts bring inst_count back to 0x0000; PC wrap at 0xFFFF_FFFC gives next fetch at 0x0.
